bp_cacc_vdp_csr: RTL and testbench



---
 rtl/bp_cacc_vdp_csr.sv | 189 ++++++++++++++++++
 tb/tb_bp_cacc_vdp_csr.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cacc_vdp_csr.sv
// Control/status register front end for the vector dot-product engine:
// decodes uncached I/O commands, holds engine configuration, issues start, captures result.
module bp_cacc_vdp_csr #(
  parameter int tag_width_p   = 16,
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     io_cmd_v_i,
  output logic                     io_cmd_ready_o,
  input  logic                     io_cmd_wr_i,
  input  logic [19:0]              io_cmd_addr_i,
  input  logic [63:0]              io_cmd_data_i,
  input  logic [tag_width_p-1:0]   io_cmd_tag_i,

  output logic                     io_resp_v_o,
  input  logic                     io_resp_yumi_i,
  output logic                     io_resp_wr_o,
  output logic [19:0]              io_resp_addr_o,
  output logic [63:0]              io_resp_data_o,
  output logic [tag_width_p-1:0]   io_resp_tag_o,

  output logic [vaddr_width_p-1:0] a_ptr_o,
  output logic [vaddr_width_p-1:0] b_ptr_o,
  output logic [vaddr_width_p-1:0] res_ptr_o,
  output logic [3:0]               len_o,
  output logic                     start_o,
  input  logic                     busy_i,
  input  logic                     done_i,
  input  logic [63:0]              result_i
);

  localparam logic [19:0] A_PTR_OFF   = 20'h00000;
  localparam logic [19:0] B_PTR_OFF   = 20'h00040;
  localparam logic [19:0] LEN_OFF     = 20'h00080;
  localparam logic [19:0] START_OFF   = 20'h000C0;
  localparam logic [19:0] STATUS_OFF  = 20'h00100;
  localparam logic [19:0] RES_PTR_OFF = 20'h00140;
  localparam logic [19:0] RESULT_OFF  = 20'h00240;

  typedef enum logic {IDLE, RESP} state_e;
  state_e state_q, state_d;

  logic [vaddr_width_p-1:0] a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, res_ptr_q, res_ptr_d;
  logic [3:0]               len_q, len_d, len_sat;
  logic                     pending_q, pending_d, done_q, done_d, err_q, err_d;
  logic                     start_q, start_d;
  logic [63:0]              result_q, result_d;

  logic                     resp_wr_q;
  logic [19:0]              resp_addr_q;
  logic [63:0]              resp_data_q, rdata;
  logic [tag_width_p-1:0]   resp_tag_q;

  logic cmd_acc, wr_acc, busy_w;
  logic sel_a, sel_b, sel_len, sel_start, sel_stat, sel_res;
  logic cfg_wr, cfg_ok, start_req, start_ok, stat_wr, err_set;

  assign io_cmd_ready_o = ~io_resp_v_o | io_resp_yumi_i;
  assign cmd_acc        = io_cmd_v_i & io_cmd_ready_o;
  assign wr_acc         = cmd_acc & io_cmd_wr_i;
  assign busy_w         = busy_i | pending_q;

  assign sel_a     = (io_cmd_addr_i == A_PTR_OFF);
  assign sel_b     = (io_cmd_addr_i == B_PTR_OFF);
  assign sel_len   = (io_cmd_addr_i == LEN_OFF);
  assign sel_start = (io_cmd_addr_i == START_OFF);
  assign sel_stat  = (io_cmd_addr_i == STATUS_OFF);
  assign sel_res   = (io_cmd_addr_i == RES_PTR_OFF);

  assign cfg_wr    = wr_acc & (sel_a | sel_b | sel_len | sel_res);
  assign cfg_ok    = cfg_wr & ~busy_w;
  assign start_req = wr_acc & sel_start & io_cmd_data_i[0];
  assign start_ok  = start_req & ~busy_w;
  assign stat_wr   = wr_acc & sel_stat;
  assign err_set   = (cfg_wr | start_req) & busy_w;

  always_comb begin
    if (io_cmd_data_i == '0)          len_sat = 4'd1;
    else if (io_cmd_data_i > 64'd8)   len_sat = 4'd8;
    else                              len_sat = io_cmd_data_i[3:0];
  end

  always_comb begin
    a_ptr_d   = a_ptr_q;
    b_ptr_d   = b_ptr_q;
    res_ptr_d = res_ptr_q;
    len_d     = len_q;
    if (cfg_ok & sel_a)   a_ptr_d   = io_cmd_data_i[vaddr_width_p-1:0];
    if (cfg_ok & sel_b)   b_ptr_d   = io_cmd_data_i[vaddr_width_p-1:0];
    if (cfg_ok & sel_res) res_ptr_d = io_cmd_data_i[vaddr_width_p-1:0];
    if (cfg_ok & sel_len) len_d     = len_sat;

    // busy_i can only be high while pending if it rose after the accepted start
    pending_d = pending_q;
    if (busy_i | done_i) pending_d = 1'b0;
    if (start_ok)        pending_d = 1'b1;

    // completion set has priority over both software clear and start clear
    done_d = done_q;
    if (stat_wr & io_cmd_data_i[0]) done_d = 1'b0;
    if (start_ok)                   done_d = 1'b0;
    if (done_i)                     done_d = 1'b1;

    err_d = err_q;
    if (stat_wr & io_cmd_data_i[2]) err_d = 1'b0;
    if (err_set)                    err_d = 1'b1;

    result_d = done_i ? result_i : result_q;
    start_d  = start_ok;
  end

  always_comb begin
    rdata = '0;
    case (io_cmd_addr_i)
      A_PTR_OFF:   rdata[vaddr_width_p-1:0] = a_ptr_q;
      B_PTR_OFF:   rdata[vaddr_width_p-1:0] = b_ptr_q;
      LEN_OFF:     rdata[3:0]               = len_q;
      STATUS_OFF:  rdata[2:0]               = {err_q, busy_w, done_q};
      RES_PTR_OFF: rdata[vaddr_width_p-1:0] = res_ptr_q;
      RESULT_OFF:  rdata                    = result_q;
      default:     rdata                    = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      res_ptr_q   <= '0;
      len_q       <= 4'd1;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      result_q    <= '0;
      resp_wr_q   <= 1'b0;
      resp_addr_q <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      a_ptr_q   <= a_ptr_d;
      b_ptr_q   <= b_ptr_d;
      res_ptr_q <= res_ptr_d;
      len_q     <= len_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      result_q  <= result_d;
      if (cmd_acc) begin
        resp_wr_q   <= io_cmd_wr_i;
        resp_addr_q <= io_cmd_addr_i;
        resp_data_q <= io_cmd_wr_i ? '0 : rdata;
        resp_tag_q  <= io_cmd_tag_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_acc) state_d = RESP;
      RESP:    if (io_resp_yumi_i) state_d = cmd_acc ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_resp_v_o = (state_q == RESP);
  end

  assign io_resp_wr_o   = resp_wr_q;
  assign io_resp_addr_o = resp_addr_q;
  assign io_resp_data_o = resp_data_q;
  assign io_resp_tag_o  = resp_tag_q;
  assign a_ptr_o        = a_ptr_q;
  assign b_ptr_o        = b_ptr_q;
  assign res_ptr_o      = res_ptr_q;
  assign len_o          = len_q;
  assign start_o        = start_q;

endmodule

// File: tb/tb_bp_cacc_vdp_csr.sv
// Bench for bp_cacc_vdp_csr: directed register-map scenarios plus random command traffic
// checked against a register-level reference model.
module tb_bp_cacc_vdp_csr;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        io_cmd_v_i, io_cmd_ready_o, io_cmd_wr_i;
  logic [19:0] io_cmd_addr_i;
  logic [63:0] io_cmd_data_i;
  logic [15:0] io_cmd_tag_i;
  logic        io_resp_v_o, io_resp_yumi_i, io_resp_wr_o;
  logic [19:0] io_resp_addr_o;
  logic [63:0] io_resp_data_o;
  logic [15:0] io_resp_tag_o;
  logic [38:0] a_ptr_o, b_ptr_o, res_ptr_o;
  logic [3:0]  len_o;
  logic        start_o, busy_i, done_i;
  logic [63:0] result_i;

  bp_cacc_vdp_csr #(.tag_width_p(16), .vaddr_width_p(39)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o), .io_cmd_wr_i(io_cmd_wr_i),
    .io_cmd_addr_i(io_cmd_addr_i), .io_cmd_data_i(io_cmd_data_i), .io_cmd_tag_i(io_cmd_tag_i),
    .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i), .io_resp_wr_o(io_resp_wr_o),
    .io_resp_addr_o(io_resp_addr_o), .io_resp_data_o(io_resp_data_o), .io_resp_tag_o(io_resp_tag_o),
    .a_ptr_o(a_ptr_o), .b_ptr_o(b_ptr_o), .res_ptr_o(res_ptr_o), .len_o(len_o),
    .start_o(start_o), .busy_i(busy_i), .done_i(done_i), .result_i(result_i)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // reference model state: the architectural register file
  logic [38:0] m_a, m_b, m_res;
  logic [3:0]  m_len;
  bit          m_done, m_err, m_pend;
  logic [63:0] m_result;

  bit          pulse_done;
  logic [63:0] pulse_val;
  logic [63:0] last_rd;
  logic        last_start;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_res = '0; m_len = 4'd1;
    m_done = 0; m_err = 0; m_pend = 0; m_result = '0;
  endtask

  function automatic logic [63:0] model_read(input logic [19:0] a);
    case (a)
      20'h000: return {25'd0, m_a};
      20'h040: return {25'd0, m_b};
      20'h080: return {60'd0, m_len};
      20'h100: return {61'd0, m_err, m_pend | busy_i, m_done};
      20'h140: return {25'd0, m_res};
      20'h240: return m_result;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_write(input logic [19:0] a, input logic [63:0] d, output bit st);
    bit busy;
    busy = m_pend | busy_i;
    st = 0;
    case (a)
      20'h000, 20'h040, 20'h080, 20'h140: begin
        if (busy) m_err = 1;
        else if (a == 20'h000) m_a = d[38:0];
        else if (a == 20'h040) m_b = d[38:0];
        else if (a == 20'h140) m_res = d[38:0];
        else m_len = (d == 0) ? 4'd1 : (d > 8) ? 4'd8 : d[3:0];
      end
      20'h0C0: if (d[0]) begin
        if (busy) m_err = 1;
        else begin m_pend = 1; m_done = 0; st = 1; end
      end
      20'h100: begin
        if (d[0]) m_done = 0;
        if (d[2]) m_err = 0;
      end
      default: ;
    endcase
  endtask

  task automatic apply_done();
    if (pulse_done) begin
      m_done = 1; m_pend = 0; m_result = pulse_val; pulse_done = 0;
    end
  endtask

  // One command with immediate yumi; optional engine done pulse in the acceptance cycle.
  task automatic cmd(input bit wr, input logic [19:0] addr, input logic [63:0] data);
    logic [63:0] exp_d;
    logic [15:0] tg;
    bit          exp_st;
    tg = 16'($urandom);
    chk("cmd_ready", {63'd0, io_cmd_ready_o}, 64'd1);
    exp_d  = wr ? 64'd0 : model_read(addr);
    exp_st = 0;
    if (wr) model_write(addr, data, exp_st);
    io_cmd_v_i = 1; io_cmd_wr_i = wr; io_cmd_addr_i = addr; io_cmd_data_i = data; io_cmd_tag_i = tg;
    if (pulse_done) begin done_i = 1; result_i = pulse_val; end
    @(posedge clk); #1;
    io_cmd_v_i = 0; done_i = 0;
    apply_done();
    chk("resp_v", {63'd0, io_resp_v_o}, 64'd1);
    chk("resp_wr", {63'd0, io_resp_wr_o}, {63'd0, wr});
    chk("resp_addr", {44'd0, io_resp_addr_o}, {44'd0, addr});
    chk("resp_tag", {48'd0, io_resp_tag_o}, {48'd0, tg});
    chk("resp_data", io_resp_data_o, exp_d);
    chk("start_pulse", {63'd0, start_o}, {63'd0, exp_st});
    last_rd = io_resp_data_o;
    last_start = start_o;
    io_resp_yumi_i = 1;
    @(posedge clk); #1;
    io_resp_yumi_i = 0;
    chk("resp_v_drop", {63'd0, io_resp_v_o}, 64'd0);
    chk("start_once", {63'd0, start_o}, 64'd0);
    chk("a_ptr_o", {25'd0, a_ptr_o}, {25'd0, m_a});
    chk("b_ptr_o", {25'd0, b_ptr_o}, {25'd0, m_b});
    chk("res_ptr_o", {25'd0, res_ptr_o}, {25'd0, m_res});
    chk("len_o", {60'd0, len_o}, {60'd0, m_len});
  endtask

  task automatic set_busy(input logic v);
    busy_i = v;
    @(posedge clk); #1;
    if (v) m_pend = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_resp_v"}, {63'd0, io_resp_v_o}, 64'd0);
    chk({tag, "_ready"}, {63'd0, io_cmd_ready_o}, 64'd1);
    chk({tag, "_start"}, {63'd0, start_o}, 64'd0);
    chk({tag, "_ptrs"}, {25'd0, a_ptr_o | b_ptr_o | res_ptr_o}, 64'd0);
    chk({tag, "_len"}, {60'd0, len_o}, 64'd1);
    chk({tag, "_resp_fields"}, {io_resp_data_o | {44'd0, io_resp_addr_o} | {48'd0, io_resp_tag_o}}
        | {63'd0, io_resp_wr_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] addrs [8];
    logic [63:0] hold_data;
    logic [15:0] hold_tag;
    int unsigned idx;
    bit          wr, st;
    logic [63:0] d;

    addrs = '{20'h000, 20'h040, 20'h080, 20'h0C0, 20'h100, 20'h140, 20'h240, 20'h3C0};
    reset_i = 1; io_cmd_v_i = 0; io_cmd_wr_i = 0; io_cmd_addr_i = '0; io_cmd_data_i = '0;
    io_cmd_tag_i = '0; io_resp_yumi_i = 0; busy_i = 0; done_i = 0; result_i = '0;
    pulse_done = 0; pulse_val = '0;
    model_reset();
    #12;
    chk_reset_state("rst");
    @(negedge clk); reset_i = 0;
    @(posedge clk); #1;
    cmd(0, 20'h100, 0); chk("rst_status", last_rd, 64'd0);
    cmd(0, 20'h240, 0); chk("rst_result", last_rd, 64'd0);

    cmd(1, 20'h000, 64'h8000_1000);
    cmd(0, 20'h000, 0); chk("a_ptr_rd", last_rd, 64'h8000_1000);
    cmd(1, 20'h040, 64'hFFFF_FFFF_FFFF_FFFF);
    cmd(0, 20'h040, 0); chk("b_ptr_trunc", last_rd, 64'h7F_FFFF_FFFF);

    cmd(1, 20'h080, 0);  cmd(0, 20'h080, 0); chk("len0", last_rd, 64'd1);
    cmd(1, 20'h080, 12); cmd(0, 20'h080, 0); chk("len12", last_rd, 64'd8);
    cmd(1, 20'h080, 64'h1_0000_0003); cmd(0, 20'h080, 0); chk("len_big", last_rd, 64'd8);
    cmd(1, 20'h080, 8);  cmd(0, 20'h080, 0); chk("len8", last_rd, 64'd8);
    cmd(1, 20'h080, 5);  cmd(0, 20'h080, 0); chk("len5", last_rd, 64'd5);

    cmd(1, 20'h0C0, 2); chk("start_bit0_clear", {63'd0, last_start}, 64'd0);
    cmd(0, 20'h0C0, 0); chk("start_rd", last_rd, 64'd0);
    cmd(1, 20'h0C0, 1); chk("start_go", {63'd0, last_start}, 64'd1);
    cmd(0, 20'h100, 0); chk("status_pend", last_rd, 64'h2);
    set_busy(1);
    cmd(0, 20'h100, 0); chk("status_busy", last_rd, 64'h2);
    busy_i = 0; done_i = 1; result_i = 64'h1234;
    @(posedge clk); #1;
    done_i = 0; m_done = 1; m_pend = 0; m_result = 64'h1234;
    cmd(0, 20'h100, 0); chk("status_done", last_rd, 64'h1);
    cmd(0, 20'h240, 0); chk("result", last_rd, 64'h1234);

    set_busy(1);
    cmd(1, 20'h0C0, 1); chk("start_busy", {63'd0, last_start}, 64'd0);
    cmd(1, 20'h040, 64'hDEAD); chk("b_ptr_kept", {25'd0, b_ptr_o}, 64'h7F_FFFF_FFFF);
    cmd(0, 20'h100, 0); chk("status_err", last_rd, 64'h7);
    cmd(1, 20'h100, 4);
    cmd(0, 20'h100, 0); chk("status_errclr", last_rd, 64'h3);
    set_busy(0);
    cmd(0, 20'h100, 0); chk("status_idle", last_rd, 64'h1);
    cmd(1, 20'h100, 1);
    cmd(0, 20'h100, 0); chk("status_doneclr", last_rd, 64'h0);

    // response held for 5 cycles, then yumi overlapped with the next command
    hold_tag = 16'hBEEF;
    io_cmd_v_i = 1; io_cmd_wr_i = 0; io_cmd_addr_i = 20'h000; io_cmd_tag_i = hold_tag;
    @(posedge clk); #1;
    io_cmd_v_i = 0;
    hold_data = io_resp_data_o;
    chk("hold_data", hold_data, 64'h8000_1000);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", {63'd0, io_cmd_ready_o}, 64'd0);
      chk("hold_v", {63'd0, io_resp_v_o}, 64'd1);
      chk("hold_stable", io_resp_data_o ^ {48'd0, io_resp_tag_o ^ hold_tag} ^ {44'd0, io_resp_addr_o},
          hold_data);
      @(posedge clk); #1;
    end
    io_resp_yumi_i = 1;
    io_cmd_v_i = 1; io_cmd_wr_i = 1; io_cmd_addr_i = 20'h140; io_cmd_data_i = 64'h55; io_cmd_tag_i = 16'h0077;
    #1 chk("b2b_ready", {63'd0, io_cmd_ready_o}, 64'd1);
    model_write(20'h140, 64'h55, st);
    @(posedge clk); #1;
    io_cmd_v_i = 0; io_resp_yumi_i = 0;
    chk("b2b_v", {63'd0, io_resp_v_o}, 64'd1);
    chk("b2b_addr", {44'd0, io_resp_addr_o}, 64'h140);
    chk("b2b_tag", {48'd0, io_resp_tag_o}, 64'h77);
    io_resp_yumi_i = 1;
    @(posedge clk); #1;
    io_resp_yumi_i = 0;
    cmd(0, 20'h140, 0); chk("res_ptr_rd", last_rd, 64'h55);

    pulse_done = 1; pulse_val = 64'hABCD;
    cmd(1, 20'h100, 1);
    cmd(0, 20'h100, 0); chk("done_set_wins", last_rd, 64'h1);
    pulse_done = 1; pulse_val = 64'h777;
    cmd(0, 20'h240, 0); chk("rd_at_accept_old", last_rd, 64'hABCD);
    cmd(0, 20'h240, 0); chk("rd_after_new", last_rd, 64'h777);

    cmd(1, 20'h004, 64'h99);
    cmd(0, 20'h200, 0); chk("unmapped_rd", last_rd, 64'd0);
    cmd(0, 20'h004, 0); chk("unmapped_wr", last_rd, 64'd0);
    cmd(0, 20'h100, 0); chk("unmapped_noerr", last_rd, 64'h1);

    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 7);
      wr  = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      if (idx == 2 && $urandom_range(0, 1) == 1) d = 64'($urandom_range(0, 15));
      if (idx == 3 || idx == 4) d = 64'($urandom_range(0, 7));
      if (m_pend && !(wr && idx == 3) && $urandom_range(0, 2) == 0) begin
        pulse_done = 1; pulse_val = {$urandom, $urandom};
      end
      cmd(wr, addrs[idx], d);
    end

    // reset while a response is outstanding
    io_cmd_v_i = 1; io_cmd_wr_i = 1; io_cmd_addr_i = 20'h000; io_cmd_data_i = 64'h123; io_cmd_tag_i = 16'h1;
    @(posedge clk); #1;
    io_cmd_v_i = 0;
    chk("pre_rst_v", {63'd0, io_resp_v_o}, 64'd1);
    #2 reset_i = 1;
    #1 chk_reset_state("mid_rst");
    model_reset();
    @(negedge clk); reset_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {63'd0, io_resp_v_o}, 64'd0);
    end
    cmd(0, 20'h100, 0); chk("post_rst_status", last_rd, 64'd0);
    cmd(0, 20'h240, 0); chk("post_rst_result", last_rd, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
